// File: rtl/multi_digit_counter_pkg.sv
// Shared helpers for the cascaded digit counter and the display modules that consume its digits.
package counter_pkg;

  // Bit width of one digit of the given radix; a radix of 1 or 2 still needs one bit.
  function automatic int digit_width(input int radix);
    return (radix > 2) ? $clog2(radix) : 1;
  endfunction

  localparam int BCD_RADIX = 10;
  localparam int HEX_RADIX = 16;
  localparam int SEG_WIDTH = 7;

endpackage

// File: rtl/multi_digit_counter_digit.sv
// One radix-RADIX up/down digit: load clamp, wrap-around stepping and its terminal flag.
module updown_digit
  import counter_pkg::*;
#(
  parameter  int RADIX = 10,
  localparam int DW    = digit_width(RADIX)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          en,
  input  logic          up,
  output logic [DW-1:0] q,
  output logic          tc
);

  localparam logic [DW-1:0] MAX_VAL = DW'(RADIX - 1);

  assign tc = up ? (q == MAX_VAL) : (q == '0);

  // NOTE: state registers use non-blocking assignments so every digit samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= (d > MAX_VAL) ? MAX_VAL : d;
    end else if (en) begin
      if (up) q <= (q == MAX_VAL) ? '0 : q + DW'(1);
      else    q <= (q == '0) ? MAX_VAL : q - DW'(1);
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded DIGITS-digit radix-RADIX up/down counter; all digits step on the same clock edge.
module multi_digit_counter
  import counter_pkg::*;
#(
  parameter  int RADIX  = 10,
  parameter  int DIGITS = 3,
  localparam int DW     = digit_width(RADIX)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] d,
  input  logic                 count,
  input  logic                 up,
  output logic [DIGITS*DW-1:0] q,
  output logic                 co,
  output logic                 bo,
  output logic [DIGITS-1:0]    tc
);

  logic [DIGITS-1:0] en;
  logic              wrap_en;

  // A digit steps only when every lower digit is at its terminal value in the current direction.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign en[i] = count;
    end else begin : g_rest
      assign en[i] = count & (&tc[i-1:0]);
    end

    updown_digit #(.RADIX(RADIX)) u_digit (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .load  (load),
      .d     (d[i*DW +: DW]),
      .en    (en[i]),
      .up    (up),
      .q     (q[i*DW +: DW]),
      .tc    (tc[i])
    );
  end

  assign wrap_en = count & (&tc);
  assign co      = wrap_en & up;
  assign bo      = wrap_en & ~up;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench: 3-digit BCD counter plus a 2-digit hex instance for the radix-16 corner cases.
module tb_multi_digit_counter;

  typedef struct {
    logic        clear;
    logic        load;
    logic [11:0] d;
    logic        count;
    logic        up;
    logic [11:0] exp_q;
    logic        exp_co;
    logic        exp_bo;
    logic [2:0]  exp_tc;
    string       name;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        clear, load, count, up;
  logic [11:0] d, q;
  logic        co, bo;
  logic [2:0]  tc;

  logic        h_clear, h_load, h_count, h_up;
  logic [7:0]  h_d, h_q;
  logic        h_co, h_bo;
  logic [1:0]  h_tc;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] sb[$];
  vec_t        vecs[15];
  vec_t        v;

  multi_digit_counter #(.RADIX(10), .DIGITS(3)) dut (
    .clock (clock), .reset (reset), .clear (clear), .load (load), .d (d),
    .count (count), .up (up), .q (q), .co (co), .bo (bo), .tc (tc)
  );

  multi_digit_counter #(.RADIX(16), .DIGITS(2)) dut_hex (
    .clock (clock), .reset (reset), .clear (h_clear), .load (h_load), .d (h_d),
    .count (h_count), .up (h_up), .q (h_q), .co (h_co), .bo (h_bo), .tc (h_tc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] bcd(input int n);
    return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Called just after a falling edge: drive, check the combinational flags, then the post-edge value.
  task automatic apply_step(input vec_t s);
    clear = s.clear; load = s.load; d = s.d; count = s.count; up = s.up;
    #1;
    check({s.name, " co"}, 32'(co), 32'(s.exp_co));
    check({s.name, " bo"}, 32'(bo), 32'(s.exp_bo));
    check({s.name, " tc"}, 32'(tc), 32'(s.exp_tc));
    sb.push_back(s.exp_q);
    @(posedge clock);
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s q: scoreboard empty, got %0h", s.name, q);
    end else begin
      check({s.name, " q"}, 32'(q), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 12'h199, 1'b0, 1'b1, 12'h199, 1'b0, 1'b0, 3'b000, "load_199"};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h200, 1'b0, 1'b0, 3'b011, "step_199"};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 3'b000, "hold_200"};
    vecs[3]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 3'b000, "clear"};
    vecs[4]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h999, 1'b0, 1'b1, 3'b111, "borrow_wrap"};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h998, 1'b0, 1'b0, 3'b000, "down_999"};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h997, 1'b0, 1'b0, 3'b000, "down_998"};
    vecs[7]  = '{1'b0, 1'b1, 12'h123, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 3'b110, "load_123"};
    vecs[8]  = '{1'b1, 1'b1, 12'h555, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 3'b000, "clear_wins"};
    vecs[9]  = '{1'b0, 1'b1, 12'h555, 1'b1, 1'b1, 12'h555, 1'b0, 1'b0, 3'b000, "load_wins"};
    vecs[10] = '{1'b0, 1'b1, 12'hFCA, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 3'b000, "load_clamp"};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 3'b111, "carry_wrap"};
    vecs[12] = '{1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 3'b000, "load_999"};
    vecs[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 3'b111, "co_under_clear"};
    vecs[14] = '{1'b0, 1'b1, 12'h456, 1'b1, 1'b0, 12'h456, 1'b0, 1'b1, 3'b111, "bo_under_load"};

    reset = 1'b1; clear = 1'b0; load = 1'b0; d = '0; count = 1'b0; up = 1'b1;
    h_clear = 1'b0; h_load = 1'b0; h_d = '0; h_count = 1'b0; h_up = 1'b1;

    // Reset state and flag behaviour while reset is held.
    @(negedge clock);
    @(negedge clock);
    count = 1'b1; up = 1'b0;
    #1;
    check("reset q", 32'(q), 32'h000);
    check("reset hex q", 32'(h_q), 32'h00);
    check("reset bo down", 32'(bo), 32'd1);
    check("reset co down", 32'(co), 32'd0);
    check("reset tc down", 32'(tc), 32'b111);
    up = 1'b1;
    #1;
    check("reset tc up", 32'(tc), 32'b000);
    check("reset bo up", 32'(bo), 32'd0);
    @(negedge clock);
    reset = 1'b0; count = 1'b0;

    // Full up-count walk 000..999 and back to 000.
    for (int n = 0; n < 1000; n++) begin
      v.clear  = 1'b0;
      v.load   = 1'b0;
      v.d      = '0;
      v.count  = 1'b1;
      v.up     = 1'b1;
      v.exp_q  = bcd((n + 1) % 1000);
      v.exp_co = (n == 999);
      v.exp_bo = 1'b0;
      v.exp_tc = {(n / 100 % 10) == 9, (n / 10 % 10) == 9, (n % 10) == 9};
      v.name   = $sformatf("walk_%0d", n);
      apply_step(v);
    end

    for (int i = 0; i < 15; i++) apply_step(vecs[i]);

    // Asynchronous reset between edges while counting from 456.
    clear = 1'b0; load = 1'b0; count = 1'b1; up = 1'b1;
    @(posedge clock);
    #1;
    check("pre_reset q", 32'(q), 32'h457);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset q", 32'(q), 32'h000);
    check("async_reset co", 32'(co), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_held q", 32'(q), 32'h000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("first_after_reset q", 32'(q), 32'h001);
    @(negedge clock);
    count = 1'b0;

    // Radix-16, 2-digit instance: no clamp at F, full wrap both ways.
    h_load = 1'b1; h_d = 8'hFF; h_up = 1'b1;
    @(negedge clock);
    check("hex load q", 32'(h_q), 32'hFF);
    h_load = 1'b0; h_count = 1'b1;
    #1;
    check("hex carry co", 32'(h_co), 32'd1);
    check("hex carry tc", 32'(h_tc), 32'b11);
    @(negedge clock);
    check("hex wrap q", 32'(h_q), 32'h00);
    check("hex after co", 32'(h_co), 32'd0);
    h_up = 1'b0;
    #1;
    check("hex borrow bo", 32'(h_bo), 32'd1);
    @(negedge clock);
    check("hex borrow q", 32'(h_q), 32'hFF);
    h_count = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
